// File: rtl/ctrl_pkg.sv
// Shared types for the control unit: opcodes, FSM state codes, ALU selects, field slices and the control bundle.
// Pure definitions: no latency, no backpressure.
package ctrl_pkg;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int ADDR_MSB = 11;
    localparam int ADDR_LSB = 4;
    localparam int RA_MSB   = 11;
    localparam int RA_LSB   = 8;
    localparam int RB_MSB   = 7;
    localparam int RB_LSB   = 4;
    localparam int RD_MSB   = 3;
    localparam int RD_LSB   = 0;

    localparam int D_AW = ADDR_MSB - ADDR_LSB + 1;
    localparam int R_AW = RD_MSB - RD_LSB + 1;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5
    } opcode_t;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    typedef struct packed {
        logic            pc_clr;
        logic            pc_up;
        logic            ir_ld;
        logic [D_AW-1:0] d_addr;
        logic            d_wr;
        logic            rf_s;
        logic [R_AW-1:0] rf_w_addr;
        logic            rf_w_en;
        logic [R_AW-1:0] rf_ra_addr;
        logic [R_AW-1:0] rf_rb_addr;
        logic [2:0]      alu_s0;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode: maps the current state plus instruction fields onto the control bundle.
// Purely combinational (zero latency); no backpressure.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [11:0] instr,
    output ctrl_t       ctl
);

    always_comb begin
        ctl = '0;
        case (state)
            S_INIT:   ctl.pc_clr = 1'b1;
            S_FETCH: begin
                ctl.ir_ld = 1'b1;
                ctl.pc_up = 1'b1;
            end
            // operands are pre-read here so the execute cycle sees settled RF data
            S_DECODE: begin
                ctl.rf_ra_addr = instr[RA_MSB:RA_LSB];
                ctl.rf_rb_addr = instr[RB_MSB:RB_LSB];
            end
            S_STORE: begin
                ctl.d_addr     = instr[ADDR_MSB:ADDR_LSB];
                ctl.rf_ra_addr = instr[RD_MSB:RD_LSB];
                ctl.alu_s0     = ALU_PASS;
                ctl.d_wr       = 1'b1;
            end
            S_LOAD_A: begin
                ctl.d_addr = instr[ADDR_MSB:ADDR_LSB];
                ctl.rf_s   = 1'b1;
            end
            S_LOAD_B: begin
                ctl.d_addr    = instr[ADDR_MSB:ADDR_LSB];
                ctl.rf_s      = 1'b1;
                ctl.rf_w_addr = instr[RD_MSB:RD_LSB];
                ctl.rf_w_en   = 1'b1;
            end
            S_ADD, S_SUB: begin
                ctl.rf_ra_addr = instr[RA_MSB:RA_LSB];
                ctl.rf_rb_addr = instr[RB_MSB:RB_LSB];
                ctl.alu_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
                ctl.rf_w_addr  = instr[RD_MSB:RD_LSB];
                ctl.rf_w_en    = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Processor control FSM: fetch/decode/execute sequencer, 3 cycles per instruction (LOAD 4), HALT parks until reset.
// No backpressure. Optional ILLEGAL_OP_TRAP_EN: undefined opcodes trap to HALT and raise a sticky Illegal.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int AW = 8,
    parameter int RW = 4
) (
    input  logic          Clk,
    input  logic          ResetN,
    input  logic [15:0]   Instruction,
    output logic          PC_Clr,
    output logic          PC_Up,
    output logic          IR_Ld,
    output logic [AW-1:0] D_Addr,
    output logic          D_Wr,
    output logic          RF_s,
    output logic [RW-1:0] RF_W_addr,
    output logic          RF_W_en,
    output logic [RW-1:0] RF_Ra_addr,
    output logic [RW-1:0] RF_Rb_addr,
    output logic [2:0]    ALU_s0,
    output logic          Illegal,
    output logic [3:0]    OutState
);

    state_t  state;
    state_t  state_nxt;
    opcode_t op;
    ctrl_t   ctl;

    assign op = opcode_t'(Instruction[OP_MSB:OP_LSB]);

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_NOOP:  state_nxt = S_NOOP;
                    OP_STORE: state_nxt = S_STORE;
                    OP_LOAD:  state_nxt = S_LOAD_A;
                    OP_ADD:   state_nxt = S_ADD;
                    OP_SUB:   state_nxt = S_SUB;
                    OP_HALT:  state_nxt = S_HALT;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:  state_nxt = S_HALT;
`else
                    default:  state_nxt = S_NOOP;
`endif
                endcase
            end
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B, S_NOOP, S_STORE, S_ADD, S_SUB: state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_INIT;
        endcase
    end

    // async clear drops the state to INIT at once, which kills any write strobe combinationally
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) state <= S_INIT;
        else         state <= state_nxt;
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN)
            illegal_q <= 1'b0;
        else if (state == S_DECODE && op > OP_HALT)
            illegal_q <= 1'b1;
    end
    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif

    ctrl_decode u_decode (
        .state (state),
        .instr (Instruction[11:0]),
        .ctl   (ctl)
    );

    assign PC_Clr     = ctl.pc_clr;
    assign PC_Up      = ctl.pc_up;
    assign IR_Ld      = ctl.ir_ld;
    assign D_Addr     = ctl.d_addr;
    assign D_Wr       = ctl.d_wr;
    assign RF_s       = ctl.rf_s;
    assign RF_W_addr  = ctl.rf_w_addr;
    assign RF_W_en    = ctl.rf_w_en;
    assign RF_Ra_addr = ctl.rf_ra_addr;
    assign RF_Rb_addr = ctl.rf_rb_addr;
    assign ALU_s0     = ctl.alu_s0;
    assign OutState   = state;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: walks reset, LOAD/STORE/ADD/SUB/undefined/HALT and mid-instruction reset.
module tb_ctrl_fsm;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic [15:0] Instruction;
    logic        PC_Clr, PC_Up, IR_Ld, D_Wr, RF_s, RF_W_en, Illegal;
    logic [7:0]  D_Addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
    logic [2:0]  ALU_s0;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    ctrl_fsm dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .Instruction(Instruction),
        .PC_Clr     (PC_Clr),
        .PC_Up      (PC_Up),
        .IR_Ld      (IR_Ld),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .Illegal    (Illegal),
        .OutState   (OutState)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // any of the seven strobes packed together, for "no strobes" checks
    function automatic logic [6:0] strobes();
        return {PC_Clr, PC_Up, IR_Ld, D_Wr, RF_s, RF_W_en, Illegal};
    endfunction

    initial begin
        ResetN      = 1'b0;
        Instruction = 16'h0000;
        #12;
        chk("rst_state",  {12'd0, OutState}, 16'd0);
        chk("rst_pcclr",  {15'd0, PC_Clr}, 16'd1);
        chk("rst_strobe", {9'd0, strobes()}, 16'h0040);
        chk("rst_daddr",  {8'd0, D_Addr}, 16'd0);
        chk("rst_rfaddr", {4'd0, RF_W_addr, RF_Ra_addr, RF_Rb_addr}, 16'd0);
        chk("rst_alu",    {13'd0, ALU_s0}, 16'd0);

        ResetN = 1'b1;
        step();
        chk("fetch_state", {12'd0, OutState}, 16'd1);
        chk("fetch_strb",  {9'd0, strobes()}, 16'h0030);

        // LOAD 0xAB -> R5
        Instruction = 16'h2AB5;
        step();
        chk("dec_state", {12'd0, OutState}, 16'd2);
        chk("dec_pre",   {8'd0, RF_Ra_addr, RF_Rb_addr}, 16'h00AB);
        chk("dec_wr",    {14'd0, D_Wr, RF_W_en}, 16'd0);
        step();
        chk("lda_state", {12'd0, OutState}, 16'd4);
        chk("lda_daddr", {8'd0, D_Addr}, 16'h00AB);
        chk("lda_ctl",   {14'd0, RF_s, RF_W_en}, 16'b10);
        step();
        chk("ldb_state", {12'd0, OutState}, 16'd5);
        chk("ldb_wr",    {10'd0, RF_s, RF_W_en, RF_W_addr}, 16'h0035);
        chk("ldb_daddr", {8'd0, D_Addr}, 16'h00AB);
        step();
        chk("ld_done", {12'd0, OutState}, 16'd1);

        // STORE R3 -> 0x42
        Instruction = 16'h1423;
        step();
        step();
        chk("st_state", {12'd0, OutState}, 16'd6);
        chk("st_daddr", {8'd0, D_Addr}, 16'h0042);
        chk("st_ra",    {12'd0, RF_Ra_addr}, 16'd3);
        chk("st_wr",    {11'd0, D_Wr, RF_W_en, ALU_s0}, 16'b10000);
        step();
        chk("st_done",  {12'd0, OutState}, 16'd1);
        chk("st_wroff", {15'd0, D_Wr}, 16'd0);

        // ADD R7 = R1 + R2
        Instruction = 16'h3127;
        step();
        step();
        chk("add_state", {12'd0, OutState}, 16'd7);
        chk("add_addr",  {4'd0, RF_Ra_addr, RF_Rb_addr, RF_W_addr}, 16'h0127);
        chk("add_ctl",   {11'd0, ALU_s0, RF_W_en, RF_s}, 16'b00110);
        step();

        // SUB R7 = R1 - R2
        Instruction = 16'h4127;
        step();
        step();
        chk("sub_state", {12'd0, OutState}, 16'd8);
        chk("sub_ctl",   {11'd0, ALU_s0, RF_W_en, RF_s}, 16'b01010);
        chk("sub_addr",  {4'd0, RF_Ra_addr, RF_Rb_addr, RF_W_addr}, 16'h0127);
        step();

        // undefined opcode
        Instruction = 16'hF000;
        step();
        step();
`ifdef ILLEGAL_OP_TRAP_EN
        chk("ill_state", {12'd0, OutState}, 16'd9);
        chk("ill_flag",  {15'd0, Illegal}, 16'd1);
        step();
        chk("ill_hold",  {15'd0, Illegal}, 16'd1);
`else
        chk("ill_state", {12'd0, OutState}, 16'd3);
        chk("ill_flag",  {15'd0, Illegal}, 16'd0);
        step();
        chk("ill_fetch", {12'd0, OutState}, 16'd1);
`endif

        // reset pulse, then reset in the middle of a LOAD write cycle
        ResetN = 1'b0;
        #1;
        chk("rst2_state", {12'd0, OutState}, 16'd0);
        chk("rst2_ill",   {15'd0, Illegal}, 16'd0);
        ResetN = 1'b1;
        step();
        Instruction = 16'h2AB5;
        step();
        step();
        step();
        chk("ldb2_wen", {15'd0, RF_W_en}, 16'd1);
        ResetN = 1'b0;
        #1;
        chk("ldb_rst_wen",   {15'd0, RF_W_en}, 16'd0);
        chk("ldb_rst_state", {12'd0, OutState}, 16'd0);
        ResetN = 1'b1;
        step();
        chk("rst3_fetch", {12'd0, OutState}, 16'd1);

        // HALT parks for good with no strobes
        Instruction = 16'h5000;
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt_state", {12'd0, OutState}, 16'd9);
            chk("halt_strb",  {9'd0, strobes()}, 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
